// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset defaults,
// FSM state encoding and small PC helpers.
package ifetch_unit_pkg;

    localparam int          XLEN            = 32;
    localparam int          IMEM_ADDR_W_DEF = 14;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF    = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Only the two low byte-offset bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_hold_buf.sv
// Capture/hold register for the fetched instruction plus the inst output mux,
// so decode sees a stable instruction for the whole length of a stall.
module ifetch_hold_buf
    import ifetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst
);

    logic            hold_valid;
    logic [XLEN-1:0] hold_inst;

    // The BRAM output is only trustworthy in the first stall cycle, so grab it
    // there; any non-stall edge issues a new fetch and the buffer is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_inst  <= NOP_INST;
        end else if (!stall) begin
            hold_valid <= 1'b0;
        end else if (inst_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_inst  <= imem_rdata;
        end
    end

    always_comb begin
        inst = NOP_INST;
        if (hold_valid) begin
            inst = hold_inst;
        end else if (inst_valid) begin
            inst = imem_rdata;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and presents {pc, inst, inst_valid} to decode with zero-bubble redirects.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int              IMEM_ADDR_W = IMEM_ADDR_W_DEF,
    parameter logic [XLEN-1:0] NOP_INST    = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    output logic [XLEN-1:0]        pc,
    output logic [XLEN-1:0]        pc_plus4,
    output logic [XLEN-1:0]        inst,
    output logic                   inst_valid,
    output logic                   misalign_err,
    output fetch_state_t           state_dbg
);

    // Control semantics: stall=1 holds pc/inst and issues no fetch; redirect is
    // only honoured in a cycle with stall=0 (stall wins), so downstream must keep
    // redirect asserted until the stall drops if it still wants the branch.

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_q;
    logic            inst_valid_q;
    logic            misalign_q;

    logic            take_redirect;
    logic            bad_target;
    logic            issue;
    logic [XLEN-1:0] sel_pc;

    assign take_redirect = (state_q == ST_RUN) && redirect && !stall;
    assign bad_target    = take_redirect && is_misaligned(redirect_pc[1:0]);
    // In BOOT fetch_pc_q still holds RESET_PC, so the same select covers it.
    assign sel_pc        = take_redirect ? redirect_pc : fetch_pc_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = bad_target ? ST_FAULT : ST_RUN;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // Output logic: BOOT always fetches, gated by rst so reset drives imem_en low.
    always_comb begin
        issue = 1'b0;
        case (state_q)
            ST_BOOT:  issue = rst;
            ST_RUN:   issue = !stall && !bad_target;
            ST_FAULT: issue = 1'b0;
            default:  issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else if (issue) begin
            pc_q         <= sel_pc;
            fetch_pc_q   <= pc_inc(sel_pc);
            inst_valid_q <= 1'b1;
        end else if (state_d == ST_FAULT) begin
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b1;
        end
    end

    ifetch_hold_buf #(
        .NOP_INST (NOP_INST)
    ) u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .inst_valid (inst_valid_q),
        .imem_rdata (imem_rdata),
        .inst       (inst)
    );

    // Upper PC bits are dropped, so the memory aliases across the address space.
    assign imem_en      = issue;
    assign imem_addr    = sel_pc[IMEM_ADDR_W+1:2];
    assign pc           = pc_q;
    assign pc_plus4     = pc_inc(pc_q);
    assign inst_valid   = inst_valid_q;
    assign misalign_err = misalign_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// stall/redirect traffic, all checked against a behavioural fetch model.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          AW       = 14;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          misalign_err;
  fetch_state_t  state_dbg;

  ifetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .misalign_err (misalign_err),
    .state_dbg    (state_dbg)
  );

  // synchronous ROM; output is scrambled whenever no read is enabled
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= $urandom;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  // behavioural fetch model
  bit          m_boot;
  bit          m_fault;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  function automatic logic [31:0] mem_at(input logic [31:0] byte_addr);
    return mem[byte_addr[AW+1:2]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_fault = 1'b0;
    m_valid = 1'b0;
    m_pc    = RESET_PC;
    m_next  = RESET_PC + 32'd4;
  endtask

  task automatic check_outputs(input string where);
    if (!m_fault) begin
      chk({where, "_pc"}, pc, m_pc);
      chk({where, "_pc_plus4"}, pc_plus4, m_pc + 32'd4);
    end
    chk({where, "_inst_valid"}, {31'd0, inst_valid}, {31'd0, m_valid});
    chk({where, "_misalign"}, {31'd0, misalign_err}, {31'd0, m_fault});
    chk({where, "_inst"}, inst, m_valid ? mem_at(m_pc) : NOP);
  endtask

  // driver: one clock cycle of stimulus, starting and ending at a negedge
  task automatic step(input bit s, input bit r, input logic [31:0] rpc);
    bit          exp_en;
    logic [31:0] tgt;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
    tgt = m_next;
    if (m_fault)     exp_en = 1'b0;
    else if (m_boot) begin exp_en = 1'b1; tgt = RESET_PC; end
    else if (s)      exp_en = 1'b0;
    else if (r)      begin tgt = rpc; exp_en = (rpc[1:0] == 2'b00); end
    else             exp_en = 1'b1;
    chk("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
    if (exp_en) chk("imem_addr", {18'd0, imem_addr}, {18'd0, tgt[AW+1:2]});
    check_outputs("pre");
    @(posedge clk);
    if (m_fault) begin
    end else if (m_boot) begin
      m_boot  = 1'b0;
      m_pc    = RESET_PC;
      m_next  = RESET_PC + 32'd4;
      m_valid = 1'b1;
    end else if (s) begin
    end else if (r && rpc[1:0] != 2'b00) begin
      m_fault = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_pc    = tgt;
      m_next  = tgt + 32'd4;
      m_valid = 1'b1;
    end
    @(negedge clk);
    check_outputs("post");
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    chk("reset_imem_en", {31'd0, imem_en}, 32'd0);
    chk("reset_state", {30'd0, state_dbg}, {30'd0, ST_BOOT});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    apply_reset();

    // boot and sequential fetch: 0x0, 0x4, 0x8
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // zero-bubble redirect from 0x8 to 0x100
    step(1'b0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0);

    // stall three cycles at 0x10 while the ROM output is scrambled
    step(1'b0, 1'b1, 32'h0000_0010);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // redirect together with stall is dropped
    step(1'b0, 1'b1, 32'h0000_0020);
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 32'h0);

    // 32-bit wrap of the PC
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // random traffic with aligned redirects
    for (int i = 0; i < 300; i++) begin
      bit          s;
      bit          r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 4) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
      step(s, r, t);
    end

    // asynchronous reset mid-run at 0x80, then refetch from RESET_PC
    step(1'b0, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0080);
    #3;
    apply_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // misaligned redirect is sticky until reset
    step(1'b0, 1'b1, 32'h0000_0102);
    chk("fault_state", {30'd0, state_dbg}, {30'd0, ST_FAULT});
    for (int i = 0; i < 6; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
    end
    apply_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
